// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge datapath: streams one picture from the source RAM into
// the Sobel block, captures edge bits into the edge RAM, drains the pipeline, reports status.
module sobel_frame_ctrl #(
   parameter int unsigned HOR_PIC   = 160,
   parameter int unsigned VERT_PIC  = 160,
   parameter int unsigned SRC_AW    = 15,
   parameter int unsigned EDGE_AW   = 15,
   parameter int unsigned DRAIN_MAX = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               src_rd,
   output logic [SRC_AW-1:0]  src_addr,
   input  logic [7:0]         src_data,
   output logic               sob_rst_n,
   output logic               sob_ready,
   output logic [7:0]         sob_data,
   input  logic               sob_bit,
   input  logic               sob_valid,
   output logic               edge_we,
   output logic [EDGE_AW-1:0] edge_addr,
   output logic               edge_din,
   output logic [15:0]        frame_cnt,
   output logic [EDGE_AW:0]   edge_ones
);

   localparam int unsigned NPix  = HOR_PIC * VERT_PIC;
   localparam int unsigned NEdge = (HOR_PIC - 2) * (VERT_PIC - 2);
   localparam int unsigned EcW   = EDGE_AW + 1;
   localparam int unsigned DcW   = $clog2(DRAIN_MAX + 1);

   localparam logic [SRC_AW-1:0] LastAddr  = SRC_AW'(NPix - 1);
   localparam logic [EcW-1:0]    EdgeTotal = EcW'(NEdge);
   localparam logic [DcW-1:0]    DrainLast = DcW'(DRAIN_MAX - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                src_rd_q, src_rd_d;
   logic [SRC_AW-1:0]   src_addr_q, src_addr_d;
   logic                sob_ready_q, sob_ready_d;
   logic                edge_we_q, edge_we_d;
   logic [EDGE_AW-1:0]  edge_addr_q, edge_addr_d;
   logic                edge_din_q, edge_din_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [EcW-1:0]      edge_ones_q, edge_ones_d;
   logic [EcW-1:0]      wr_cnt_q, wr_cnt_d;
   logic [DcW-1:0]      dcnt_q, dcnt_d;
   logic                capture;

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      src_addr_d  = src_addr_q;
      edge_we_d   = 1'b0;
      edge_addr_d = edge_addr_q;
      edge_din_d  = edge_din_q;
      frame_cnt_d = frame_cnt_q;
      edge_ones_d = edge_ones_q;
      wr_cnt_d    = wr_cnt_q;
      dcnt_d      = dcnt_q;

      // An aborting cycle writes nothing; once the frame is full, extra results are dropped.
      capture = (state_q == StFeed || state_q == StDrain) && !abort && sob_valid &&
                (wr_cnt_q != EdgeTotal);
      if (capture) begin
         edge_we_d   = 1'b1;
         edge_addr_d = wr_cnt_q[EDGE_AW-1:0];
         edge_din_d  = sob_bit;
         wr_cnt_d    = wr_cnt_q + EcW'(1);
         edge_ones_d = edge_ones_q + EcW'(sob_bit);
      end

      unique case (state_q)
         StIdle: begin
            src_addr_d = '0;
            if (start) begin
               state_d     = StFeed;
               wr_cnt_d    = '0;
               edge_ones_d = '0;
               err_d       = 1'b0;
            end
         end
         StFeed: begin
            if (abort) begin
               state_d = StIdle;
            end else if (src_addr_q == LastAddr) begin
               state_d = StDrain;
               dcnt_d  = '0;
            end else begin
               src_addr_d = src_addr_q + SRC_AW'(1);
            end
         end
         StDrain: begin
            dcnt_d = dcnt_q + DcW'(1);
            // Completion is judged on the post-capture count so a last write wins the timeout.
            if (abort) begin
               state_d = StIdle;
            end else if (wr_cnt_d == EdgeTotal) begin
               state_d = StDone;
            end else if (dcnt_q == DrainLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            if (!abort) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      src_rd_d    = (state_d == StFeed);
      sob_ready_d = src_rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         src_rd_q    <= 1'b0;
         src_addr_q  <= '0;
         sob_ready_q <= 1'b0;
         edge_we_q   <= 1'b0;
         edge_addr_q <= '0;
         edge_din_q  <= 1'b0;
         frame_cnt_q <= '0;
         edge_ones_q <= '0;
         wr_cnt_q    <= '0;
         dcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         src_rd_q    <= src_rd_d;
         src_addr_q  <= src_addr_d;
         sob_ready_q <= sob_ready_d;
         edge_we_q   <= edge_we_d;
         edge_addr_q <= edge_addr_d;
         edge_din_q  <= edge_din_d;
         frame_cnt_q <= frame_cnt_d;
         edge_ones_q <= edge_ones_d;
         wr_cnt_q    <= wr_cnt_d;
         dcnt_q      <= dcnt_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign src_rd    = src_rd_q;
   assign src_addr  = src_addr_q;
   assign sob_rst_n = busy_q;
   assign sob_ready = sob_ready_q;
   assign sob_data  = src_data;
   assign edge_we   = edge_we_q;
   assign edge_addr = edge_addr_q;
   assign edge_din  = edge_din_q;
   assign frame_cnt = frame_cnt_q;
   assign edge_ones = edge_ones_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on an 8x8 picture: source RAM model, Sobel stand-in with a golden
// gradient model, and a per-cycle expectation built from frame-level timing rules.
module tb_sobel_frame_ctrl;

   localparam int W = 8, H = 8, N = W * H, E = (W - 2) * (H - 2);
   localparam int DM = 16, LAT = 3, FLOOD = 40;
   localparam int ModeNormal = 0, ModeNever = 1, ModeFlood = 2, ModeAbort = 3;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic       busy, done, err, src_rd, sob_rst_n, sob_ready, edge_we, edge_din;
   logic [7:0] src_addr;
   logic [7:0] src_data = 8'd0;
   logic [7:0] sob_data;
   logic       sob_bit = 1'b0, sob_valid = 1'b0;
   logic [5:0] edge_addr;
   logic [15:0] frame_cnt;
   logic [6:0] edge_ones;

   logic [7:0] img [N];
   logic [7:0] rx  [N];
   bit         exp_bits [E];
   bit         flood_bits [FLOOD];
   int         cyc = 0, t0 = 0, mode = ModeNormal, flood_st = 0, rx_n = 0;
   int         n_tests = 0, n_fail = 0, fc_exp = 0;
   bit         q_bit [$];
   int         q_t [$];

   always #5 clk = ~clk;

   sobel_frame_ctrl #(
      .HOR_PIC(W), .VERT_PIC(H), .SRC_AW(8), .EDGE_AW(6), .DRAIN_MAX(DM)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data), .sob_rst_n(sob_rst_n),
      .sob_ready(sob_ready), .sob_data(sob_data), .sob_bit(sob_bit), .sob_valid(sob_valid),
      .edge_we(edge_we), .edge_addr(edge_addr), .edge_din(edge_din), .frame_cnt(frame_cnt),
      .edge_ones(edge_ones)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (src_rd) src_data <= img[src_addr[5:0]];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Golden Sobel: |Gx|+|Gy| over the 3x3 window centred at (r,c), edge when above 230.
   function automatic bit sobel_at(input bit use_rx, input int r, input int c);
      int p [3][3];
      int gx, gy;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = use_rx ? int'(rx[(r + i - 1) * W + c + j - 1])
                             : int'(img[(r + i - 1) * W + c + j - 1]);
      gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      return (gx + gy) > 230;
   endfunction

   // Sobel stand-in: results follow their completing pixel by LAT cycles, in raster order.
   always @(negedge clk) begin
      int rel;
      rel       = cyc - t0;
      sob_valid = 1'b0;
      sob_bit   = 1'b0;
      if (mode == ModeFlood) begin
         if (rel >= flood_st && rel < flood_st + FLOOD) begin
            sob_valid = 1'b1;
            sob_bit   = flood_bits[rel - flood_st];
         end
      end else if (!sob_rst_n) begin
         rx_n = 0;
         q_bit.delete();
         q_t.delete();
      end else if (mode != ModeNever) begin
         if (sob_ready && rx_n < N) begin
            rx[rx_n] = sob_data;
            if (rx_n / W >= 2 && rx_n % W >= 2) begin
               q_bit.push_back(sobel_at(1'b1, rx_n / W - 1, rx_n % W - 1));
               q_t.push_back(rel + LAT);
            end
            rx_n++;
         end
         if (q_t.size() > 0 && q_t[0] <= rel) begin
            sob_valid = 1'b1;
            sob_bit   = q_bit.pop_front();
            void'(q_t.pop_front());
         end
      end
   end

   task automatic set_img(input int kind);
      for (int i = 0; i < N; i++)
         case (kind)
            0:       img[i] = 8'(i);
            1:       img[i] = 8'h80;
            2:       img[i] = (((i / W) + (i % W)) % 2 == 1) ? 8'hFF : 8'h00;
            default: img[i] = 8'($urandom_range(255));
         endcase
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_flags"}, {busy, done, err, src_rd, sob_rst_n, sob_ready, edge_we, edge_din},
               32'd0);
      check_eq({tag, "_src_addr"}, src_addr, 32'd0);
      check_eq({tag, "_edge_addr"}, edge_addr, 32'd0);
      check_eq({tag, "_frame_cnt"}, frame_cnt, 32'd0);
      check_eq({tag, "_edge_ones"}, edge_ones, 32'd0);
   endtask

   // Runs one frame, checking every cycle from the first FEED cycle to the first IDLE cycle.
   task automatic run_frame(input int m, input int abort_at, input bit first, input bit hold,
                            input bit keep);
      int idle_rel, last_feed, cap_last, m_wr, ones;
      bit has_done, exp_we, busy_exp;
      case (m)
         ModeNormal: begin idle_rel = N + LAT + 3; has_done = 1'b1; end
         ModeNever:  begin idle_rel = N + 1 + DM;  has_done = 1'b0; end
         ModeFlood:  begin idle_rel = N + 3;       has_done = 1'b1; end
         default:    begin idle_rel = abort_at + 1; has_done = 1'b0; end
      endcase
      last_feed = (m == ModeAbort) ? abort_at : N;
      cap_last  = (m == ModeAbort) ? abort_at - 1 : (has_done ? idle_rel - 2 : idle_rel - 1);
      if (m == ModeFlood) begin
         flood_st = $urandom_range(20, 2);
         for (int k = 0; k < FLOOD; k++) flood_bits[k] = 1'($urandom_range(1));
         for (int k = 0; k < E; k++) exp_bits[k] = flood_bits[k];
      end else begin
         for (int k = 0; k < E; k++) exp_bits[k] = sobel_at(1'b0, 1 + k / (W - 2), 1 + k % (W - 2));
      end
      if (first) begin
         @(posedge clk); #1;
         start = 1'b1;
      end
      t0 = cyc;
      mode = m;
      m_wr = 0;
      ones = 0;
      for (int rel = 1; rel <= idle_rel; rel++) begin
         @(posedge clk); #1;
         busy_exp = (rel < idle_rel);
         check_eq("busy", busy, busy_exp);
         check_eq("sob_rst_n", sob_rst_n, busy_exp);
         check_eq("src_rd", src_rd, rel <= last_feed);
         if (rel <= last_feed) check_eq("src_addr", src_addr, rel - 1);
         check_eq("sob_ready", sob_ready, rel >= 2 && rel <= last_feed + 1);
         check_eq("done", done, has_done && rel == idle_rel - 1);
         check_eq("err", err, m == ModeNever && rel == idle_rel);
         check_eq("frame_cnt", frame_cnt, fc_exp + ((has_done && rel == idle_rel) ? 1 : 0));
         exp_we = sob_valid && (rel - 1) <= cap_last && m_wr < E;
         check_eq("edge_we", edge_we, exp_we);
         if (exp_we) begin
            check_eq("edge_addr", edge_addr, m_wr);
            check_eq("edge_din", edge_din, exp_bits[m_wr]);
            ones += int'(exp_bits[m_wr]);
            m_wr++;
         end
         if (rel == idle_rel) check_eq("edge_ones", edge_ones, ones);
         abort = (m == ModeAbort && rel == abort_at);
         if (rel == idle_rel)   start = keep;
         else if (hold)         start = 1'b1;
         else                   start = (rel >= 2 && $urandom_range(3) == 0);
      end
      if (has_done) fc_exp++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      set_img(0); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      set_img(1); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      set_img(2); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      set_img(3); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      run_frame(ModeNever, 0, 1'b1, 1'b0, 1'b0); repeat (3) @(posedge clk);
      set_img(3); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      run_frame(ModeAbort, 20, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);
      set_img(3); run_frame(ModeNormal, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);

      // Three frames back-to-back with start held high throughout.
      set_img(3);
      run_frame(ModeNormal, 0, 1'b1, 1'b1, 1'b1);
      run_frame(ModeNormal, 0, 1'b0, 1'b1, 1'b1);
      run_frame(ModeNormal, 0, 1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);

      run_frame(ModeFlood, 0, 1'b1, 1'b0, 1'b0); repeat (2) @(posedge clk);

      // Reset pulsed while draining.
      @(posedge clk); #1;
      start = 1'b1; t0 = cyc; mode = ModeNever;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (N + 4) @(posedge clk);
      #1;
      check_eq("drain_busy", busy, 1'b1);
      check_eq("drain_src_rd", src_rd, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("mid_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
